fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 4, SHALL set the width of every data word.
REQ-002 Parameter NUM_REQ, default 4, SHALL set the number of requesters, index 0..NUM_REQ-1.
REQ-003 Parameter BURST_LEN, default 2, range 1..15, SHALL set the maximum number of words written per grant.
REQ-004 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-006 req  input  NUM_REQ  SHALL be the per-requester write request, level-held while the requester has data.
REQ-007 req_data  input  NUM_REQ*DATA_WIDTH  SHALL carry requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 fifo_full  input  1  SHALL be the downstream FIFO full flag.
REQ-009 gnt  output  NUM_REQ  SHALL be the registered one-hot grant, all-zero when no owner.
REQ-010 fifo_wr_en  output  1  SHALL be the write strobe to the FIFO.
REQ-011 fifo_data  output  DATA_WIDTH  SHALL be the write data to the FIFO.
REQ-012 busy  output  1  SHALL be high whenever the state is GRANT.

Function
REQ-013 The block SHALL implement two states: IDLE and GRANT.
REQ-014 IDLE: if any req bit is high, the block SHALL select the first requester with req high, searching from rr_ptr upward with wrap-around modulo NUM_REQ, set gnt to that one-hot, load owner, clear burst_cnt, and enter GRANT on the next edge.
REQ-015 IDLE with req all zero SHALL hold IDLE with gnt = 0.
REQ-016 GRANT: a transfer SHALL occur in a cycle iff req[owner] = 1 and fifo_full = 0.
REQ-017 fifo_wr_en SHALL be combinational, equal to the transfer condition, and SHALL be 0 in IDLE.
REQ-018 fifo_data SHALL be combinational req_data[owner] in GRANT and all-zero in IDLE.
REQ-019 Each transfer SHALL increment burst_cnt (4-bit); fifo_full = 1 SHALL stall: no transfer, burst_cnt held, grant held.
REQ-020 A transfer with burst_cnt = BURST_LEN-1 SHALL end the grant: next edge enters IDLE, gnt = 0, rr_ptr = (owner+1) mod NUM_REQ.
REQ-021 req[owner] = 0 in GRANT SHALL end the grant identically to REQ-020, with no transfer that cycle.
REQ-022 Each grant SHALL be followed by at least one IDLE cycle; a requester SHALL never receive two consecutive grants while another requester has req high.
REQ-023 Changes in req of non-owners during GRANT SHALL have no effect until the next arbitration.
REQ-024 NUM_REQ = 1 SHALL degenerate to grant/idle alternation with rr_ptr fixed at 0.

Reset
REQ-025 reset high SHALL immediately force state = IDLE, gnt = 0, rr_ptr = 0, owner = 0, burst_cnt = 0, busy = 0.
REQ-026 Because of REQ-025, fifo_wr_en and fifo_data SHALL go to 0 immediately while reset is high, including mid-burst.
REQ-027 After release, the first arbitration SHALL start from requester 0.

Verification
REQ-028 Reset, req = 4'b0001, req_data[3:0] = 4'hA, fifo_full = 0 -> gnt = 0001 one cycle later; two writes of 4'hA; gnt = 0 one cycle; regrant.
REQ-029 req = 4'b1111 held, data 1,2,3,4 -> write order 1,1,2,2,3,3,4,4,1,1; one IDLE cycle between grants.
REQ-030 Owner 2 in GRANT, fifo_full = 1 for 3 cycles -> fifo_wr_en = 0 for 3 cycles, gnt held = 0100, burst completes after full drops.
REQ-031 Owner 1, req[1] drops after first word -> exactly one write, IDLE next cycle, rr_ptr = 2.
REQ-032 reset asserted mid-burst with fifo_wr_en = 1 -> fifo_wr_en, gnt, busy = 0 without waiting for clk; after release, req = 4'b1010 -> gnt = 0010.
REQ-033 req = 4'b1000 only, with BURST_LEN = 1 -> grant, one write, IDLE, regrant to requester 3, repeating.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-arbiter bus: requester side (req/req_data), FIFO side (fifo_*), and grant status.
// The master modport is the arbiter; the slave modport is whatever drives the requests and FIFO flag.
interface fifo_wr_arbiter_if #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_data;
    logic                          busy;

    modport master (
        input  req, req_data, fifo_full,
        output gnt, fifo_wr_en, fifo_data, busy
    );

    modport slave (
        output req, req_data, fifo_full,
        input  gnt, fifo_wr_en, fifo_data, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter granting one requester at a time a burst of up to BURST_LEN FIFO writes.
// Every grant is followed by an IDLE cycle, and the search pointer moves past the last owner.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int NUM_REQ    = 4,
    parameter int BURST_LEN  = 2
) (
    input  logic               clk,
    input  logic               reset,
    fifo_wr_arbiter_if.master  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic                 busy_q, busy_d;

    logic                  xfer_s;
    logic [PTR_W-1:0]      pick_s;
    logic [PTR_W-1:0]      next_ptr_s;
    logic [DATA_WIDTH-1:0] owner_data_s;

    // First requester with req high, scanning upward from start with wrap-around.
    function automatic logic [PTR_W-1:0] first_from(input logic [NUM_REQ-1:0] r,
                                                    input logic [PTR_W-1:0]   start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] sel;
        logic             found;
        idx   = start;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel   = (!found && r[idx]) ? idx : sel;
            found = found | r[idx];
            idx   = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
        end
        return sel;
    endfunction

    assign pick_s     = first_from(bus.req, rr_ptr_q);
    assign next_ptr_s = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
    assign xfer_s     = (state_q == GRANT) && bus.req[owner_q] && !bus.fifo_full;

    // Select the owner's data word with constant slice bounds.
    always_comb begin
        owner_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            owner_data_s = (owner_q == PTR_W'(i)) ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]
                                                 : owner_data_s;
        end
    end

    // Next-state logic for the IDLE/GRANT controller.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    state_d     = GRANT;
                    owner_d     = pick_s;
                    gnt_d       = NUM_REQ'(1) << pick_s;
                    burst_cnt_d = 4'd0;
                    busy_d      = 1'b1;
                end else begin
                    gnt_d  = '0;
                    busy_d = 1'b0;
                end
            end
            GRANT: begin
                // Dropped request and final beat both release the grant the same way.
                if (!bus.req[owner_q] ||
                    (xfer_s && (burst_cnt_q == 4'(BURST_LEN - 1)))) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    busy_d      = 1'b0;
                    rr_ptr_d    = next_ptr_s;
                    burst_cnt_d = xfer_s ? burst_cnt_q + 4'd1 : burst_cnt_q;
                end else if (xfer_s) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Controller state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= 4'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.busy       = busy_q;
    assign bus.fifo_wr_en = xfer_s;
    assign bus.fifo_data  = (state_q == GRANT) ? owner_data_s : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: directed stimulus queues expected FIFO words,
// negedge monitors pop and compare on every write strobe; grant/busy checked at set points.
module tb_fifo_wr_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    fifo_wr_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) bus0 ();
    fifo_wr_arbiter_if #(.DATA_WIDTH(4), .NUM_REQ(4)) bus1 ();

    fifo_wr_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .BURST_LEN(2)) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    fifo_wr_arbiter #(.DATA_WIDTH(4), .NUM_REQ(4), .BURST_LEN(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic push0(input logic [3:0] w, input int n);
        for (int i = 0; i < n; i++) q0.push_back(w);
    endtask

    // Write monitor for the BURST_LEN=2 instance.
    always @(negedge clk) begin
        logic [3:0] e;
        if (bus0.fifo_wr_en === 1'b1) begin
            if (q0.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr0_unexpected: got write %0h expected no write at %0t", bus0.fifo_data, $time);
            end else begin
                e = q0.pop_front();
                chk("wr0_data", 32'(bus0.fifo_data), 32'(e));
            end
        end
    end

    // Write monitor for the BURST_LEN=1 instance.
    always @(negedge clk) begin
        logic [3:0] e;
        if (bus1.fifo_wr_en === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL wr1_unexpected: got write %0h expected no write at %0t", bus1.fifo_data, $time);
            end else begin
                e = q1.pop_front();
                chk("wr1_data", 32'(bus1.fifo_data), 32'(e));
            end
        end
    end

    initial begin
        logic [3:0] eg;
        reset = 1'b1;
        bus0.req = 4'b0; bus0.req_data = 16'h0; bus0.fifo_full = 1'b0;
        bus1.req = 4'b0; bus1.req_data = 16'h0; bus1.fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt",   32'(bus0.gnt), 32'h0);
        chk("rst_busy",  32'(bus0.busy), 32'h0);
        chk("rst_wr_en", 32'(bus0.fifo_wr_en), 32'h0);
        chk("rst_data",  32'(bus0.fifo_data), 32'h0);
        reset = 1'b0;
        step();
        chk("idle_noreq_gnt", 32'(bus0.gnt), 32'h0);

        // Single requester: two writes, one idle cycle, regrant.
        bus0.req_data = 16'h000A;
        bus0.req      = 4'b0001;
        push0(4'hA, 4);
        step(); chk("t1_gnt", 32'(bus0.gnt), 32'h1); chk("t1_busy", 32'(bus0.busy), 32'h1);
        step();
        step(); chk("t1_idle_gnt", 32'(bus0.gnt), 32'h0); chk("t1_idle_busy", 32'(bus0.busy), 32'h0);
        chk("t1_idle_wr", 32'(bus0.fifo_wr_en), 32'h0);
        step(); chk("t1_regnt", 32'(bus0.gnt), 32'h1);
        step();
        step(); bus0.req = 4'b0;

        // All requesters: rotation 0,1,2,3,0 with two words each.
        pulse_reset();
        bus0.req_data = 16'h4321;
        bus0.req      = 4'b1111;
        push0(4'h1, 2); push0(4'h2, 2); push0(4'h3, 2); push0(4'h4, 2); push0(4'h1, 2);
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            step(); chk("t2_gnt", 32'(bus0.gnt), 32'(eg));
            step();
            step(); chk("t2_idle_gnt", 32'(bus0.gnt), 32'h0);
        end
        bus0.req = 4'b0;

        // FIFO full stalls owner 2 for three cycles.
        pulse_reset();
        bus0.req_data = 16'h0500;
        bus0.req      = 4'b0100;
        push0(4'h5, 2);
        step();
        bus0.fifo_full = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c != 0) step();
            #1;
            chk("t3_stall_gnt", 32'(bus0.gnt), 32'h4);
            chk("t3_stall_wr",  32'(bus0.fifo_wr_en), 32'h0);
        end
        step();
        bus0.fifo_full = 1'b0;
        step();
        step(); chk("t3_end_gnt", 32'(bus0.gnt), 32'h0);
        bus0.req = 4'b0;

        // Owner 1 drops after one word; pointer moves to 2.
        pulse_reset();
        bus0.req_data = 16'h0760;
        bus0.req      = 4'b0010;
        push0(4'h6, 1); push0(4'h7, 2);
        step(); chk("t4_gnt", 32'(bus0.gnt), 32'h2);
        step(); bus0.req = 4'b0;
        step(); chk("t4_idle_gnt", 32'(bus0.gnt), 32'h0); chk("t4_idle_busy", 32'(bus0.busy), 32'h0);
        bus0.req = 4'b0110;
        step(); chk("t4_rr_gnt", 32'(bus0.gnt), 32'h4);
        step();
        step(); bus0.req = 4'b0;

        // Asynchronous reset in the middle of a write.
        pulse_reset();
        bus0.req_data = 16'h4321;
        bus0.req      = 4'b1111;
        step();
        #2;
        chk("t5_pre_wr",   32'(bus0.fifo_wr_en), 32'h1);
        chk("t5_pre_data", 32'(bus0.fifo_data), 32'h1);
        reset = 1'b1;
        #1;
        chk("t5_rst_wr",   32'(bus0.fifo_wr_en), 32'h0);
        chk("t5_rst_data", 32'(bus0.fifo_data), 32'h0);
        chk("t5_rst_gnt",  32'(bus0.gnt), 32'h0);
        chk("t5_rst_busy", 32'(bus0.busy), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus0.req = 4'b1010;
        push0(4'h2, 2);
        step(); chk("t5_gnt", 32'(bus0.gnt), 32'h2);
        step();
        step(); bus0.req = 4'b0;

        // BURST_LEN=1 instance with a single requester 3.
        bus1.req_data = 16'h9000;
        bus1.req      = 4'b1000;
        for (int k = 0; k < 3; k++) q1.push_back(4'h9);
        for (int k = 0; k < 3; k++) begin
            step(); chk("t6_gnt", 32'(bus1.gnt), 32'h8); chk("t6_busy", 32'(bus1.busy), 32'h1);
            step(); chk("t6_idle_gnt", 32'(bus1.gnt), 32'h0);
        end
        bus1.req = 4'b0;

        repeat (3) step();
        chk("q0_drained", 32'(q0.size()), 32'h0);
        chk("q1_drained", 32'(q1.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
